// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data single-port memory arbiter.
// Used by mem_arbiter and arb_pick.
package mem_arbiter_pkg;

  localparam int MSIZE_W    = 3;
  localparam int REQ_ADDR_W = 64;
  localparam int REQ_DATA_W = 64;
  localparam int STRB_W     = 8;

  localparam logic [MSIZE_W-1:0] FETCH_SIZE = 3'd2;

  localparam logic LG_FETCH = 1'b0;
  localparam logic LG_DATA  = 1'b1;

  localparam int GNT_I = 0;
  localparam int GNT_D = 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic                  write;
    logic [MSIZE_W-1:0]    size;
    logic [STRB_W-1:0]     strobe;
    logic [REQ_DATA_W-1:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Grant selection for the memory arbiter; tie-break depends on
// MEM_ARB_RR_EN (round-robin) or fixed data priority when undefined.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic       i_valid,
  input  logic       d_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  logic tie_d;

`ifdef MEM_ARB_RR_EN
  assign tie_d = (last_grant == LG_FETCH);
`else
  logic unused_last;
  assign unused_last = last_grant;
  assign tie_d       = 1'b1;
`endif

  always_comb begin
    grant = 2'b00;
    if (i_valid && d_valid) begin
      grant[GNT_D] = tie_d;
      grant[GNT_I] = !tie_d;
    end else begin
      grant[GNT_D] = d_valid;
      grant[GNT_I] = i_valid;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and data requesters.
// Define MEM_ARB_RR_EN for round-robin tie-break (else data wins).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ok,
  output logic [31:0]       i_data,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_write,
  input  logic [2:0]        d_size,
  input  logic [7:0]        d_strobe,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ok,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_write,
  output logic [2:0]        m_size,
  output logic [7:0]        m_strobe,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ok,
  input  logic [DATA_W-1:0] m_rdata
);

  arb_state_t state_q, state_d;
  arb_req_t   req_q, req_d;
  logic [1:0] grant;
  logic       lg_q;

`ifdef MEM_ARB_RR_EN
  logic lg_d;

  always_comb begin
    lg_d = lg_q;
    if (state_q == IDLE && |grant) begin
      lg_d = grant[GNT_D] ? LG_DATA : LG_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) lg_q <= LG_FETCH;
    else       lg_q <= lg_d;
  end
`else
  assign lg_q = LG_FETCH;
`endif

  arb_pick u_pick (
    .i_valid   (i_valid),
    .d_valid   (d_valid),
    .last_grant(lg_q),
    .grant     (grant)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    i_ok    = 1'b0;
    d_ok    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant[GNT_D]) begin
          req_d.addr   = REQ_ADDR_W'(d_addr);
          req_d.write  = d_write;
          req_d.size   = d_size;
          req_d.strobe = d_strobe;
          req_d.wdata  = REQ_DATA_W'(d_wdata);
          state_d      = BUSY_D;
        end else if (grant[GNT_I]) begin
          req_d.addr   = REQ_ADDR_W'(i_addr);
          req_d.write  = 1'b0;
          req_d.size   = FETCH_SIZE;
          req_d.strobe = '0;
          req_d.wdata  = '0;
          state_d      = BUSY_I;
        end
      end
      BUSY_I: begin
        if (m_ok) begin
          i_ok    = 1'b1;
          state_d = IDLE;
        end
      end
      BUSY_D: begin
        if (m_ok) begin
          d_ok    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  assign m_valid  = (state_q != IDLE);
  assign m_addr   = req_q.addr[ADDR_W-1:0];
  assign m_write  = req_q.write;
  assign m_size   = req_q.size;
  assign m_strobe = req_q.strobe;
  assign m_wdata  = req_q.wdata[DATA_W-1:0];

  // Responses are zeroed outside their ok pulse so idle outputs stay quiet.
  assign i_data  = !i_ok       ? '0 :
                   req_q.addr[2] ? m_rdata[DATA_W-1:32] : m_rdata[31:0];
  assign d_rdata = d_ok ? m_rdata : '0;

endmodule
